packet_fifo_drain: RTL

- Read-side controller for the byte-wide packet FIFO. Each FIFO word is 8 data bits plus an EOD flag.
- Pulls only whole, committed packets out of the FIFO. Hides the 1-cycle registered BRAM read latency behind a 2-entry output buffer.
- Presents a valid/ready/last byte stream to the MAC transmit path and enforces a minimum inter-packet gap.
- Sits between the packet FIFO read port and the TX MAC; clocked on the same clock as the FIFO.

---
 rtl/packet_fifo_drain.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/packet_fifo_drain.sv
// Read-side drain controller for the byte-wide packet FIFO: pops only committed packets,
// hides the registered BRAM read latency behind a 2-entry buffer and enforces an inter-packet gap.
module packet_fifo_drain #(
    parameter int CNT_W      = 9,
    parameter int IFG_CYCLES = 12
) (
    input  logic             clkw,
    input  logic             rst_n,
    input  logic             i_pkt_commit,
    input  logic             i_fifo_empty,
    input  logic [7:0]       i_fifo_do,
    input  logic             i_fifo_eod,
    output logic             o_fifo_re,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    output logic             o_tx_last,
    input  logic             i_tx_ready,
    output logic [CNT_W-1:0] o_pkt_avail,
    output logic             o_ovf_err
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES);
    localparam bit               GAP_EN   = (IFG_CYCLES > 0);

    typedef enum logic [0:0] {
        ST_SEND = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    logic [CNT_W-1:0] r_pkt_avail;
    logic             r_ovf_err;
    logic             r_inflight;
    logic [7:0]       r_buf_data [2];
    logic [1:0]       r_buf_eod;
    logic             r_buf_rd_ptr;
    logic             r_buf_wr_ptr;
    logic [1:0]       r_buf_cnt;
    state_t           r_state;
    logic [GAP_W-1:0] r_gap_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_tx_valid;
    logic             w_head_eod;
    logic             w_ret_eod;
    logic             w_avail_max;
    logic             w_avail_nz;
    logic             w_avail_ge2;
    logic [1:0]       w_slots_used;
    logic             w_fifo_re;

    assign w_push      = r_inflight;
    assign w_tx_valid  = (r_state == ST_SEND) && (r_buf_cnt != 2'd0);
    assign w_pop       = w_tx_valid & i_tx_ready;
    assign w_head_eod  = r_buf_eod[r_buf_rd_ptr];
    assign w_ret_eod   = r_inflight & i_fifo_eod;
    assign w_avail_max = &r_pkt_avail;
    assign w_avail_nz  = (r_pkt_avail != {CNT_W{1'b0}});
    assign w_avail_ge2 = (r_pkt_avail >= CNT_TWO);

    // A byte leaving the buffer this cycle frees its slot for the word being requested now,
    // which is what lets a multi-packet backlog stream at one byte per clock.
    assign w_slots_used = r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

    // Back-to-back reads only when a second committed packet guarantees the next word is committed too.
    assign w_fifo_re = ~i_fifo_empty && w_avail_nz && (w_slots_used < 2'd2) &&
                       (~r_inflight || w_avail_ge2);

    assign o_fifo_re   = w_fifo_re;
    assign o_tx_valid  = w_tx_valid;
    assign o_tx_data   = r_buf_data[r_buf_rd_ptr];
    assign o_tx_last   = w_tx_valid & w_head_eod;
    assign o_pkt_avail = r_pkt_avail;
    assign o_ovf_err   = r_ovf_err;

    // Committed-packet counter and sticky overflow flag.
    always_ff @(posedge clkw or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_avail <= {CNT_W{1'b0}};
            r_ovf_err   <= 1'b0;
        end else begin
            case ({i_pkt_commit, w_ret_eod})
                2'b10: begin
                    if (!w_avail_max) begin
                        r_pkt_avail <= r_pkt_avail + CNT_ONE;
                    end else begin
                        r_pkt_avail <= r_pkt_avail;
                    end
                end
                2'b01:   r_pkt_avail <= r_pkt_avail - CNT_ONE;
                default: r_pkt_avail <= r_pkt_avail;
            endcase
            if (i_pkt_commit && w_avail_max) begin
                r_ovf_err <= 1'b1;
            end else begin
                r_ovf_err <= r_ovf_err;
            end
        end
    end

    // Tracks the single outstanding BRAM read whose data returns next cycle.
    always_ff @(posedge clkw or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_fifo_re;
        end
    end

    // Two-entry {data, eod} return buffer; push and pop may coincide.
    always_ff @(posedge clkw or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_data[0] <= 8'h00;
            r_buf_data[1] <= 8'h00;
            r_buf_eod     <= 2'b00;
            r_buf_rd_ptr  <= 1'b0;
            r_buf_wr_ptr  <= 1'b0;
            r_buf_cnt     <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_buf_wr_ptr] <= i_fifo_do;
                r_buf_eod[r_buf_wr_ptr]  <= i_fifo_eod;
                r_buf_wr_ptr             <= ~r_buf_wr_ptr;
            end else begin
                r_buf_wr_ptr <= r_buf_wr_ptr;
            end
            if (w_pop) begin
                r_buf_rd_ptr <= ~r_buf_rd_ptr;
            end else begin
                r_buf_rd_ptr <= r_buf_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
                2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
                default: r_buf_cnt <= r_buf_cnt;
            endcase
        end
    end

    // Output FSM: SEND streams the buffer head, GAP holds tx_valid low for the inter-packet gap.
    always_ff @(posedge clkw or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SEND;
            r_gap_cnt <= {GAP_W{1'b0}};
        end else begin
            case (r_state)
                ST_SEND: begin
                    if (w_pop && w_head_eod && GAP_EN) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= GAP_LOAD;
                    end else begin
                        r_state   <= ST_SEND;
                        r_gap_cnt <= r_gap_cnt;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt <= GAP_ONE) begin
                        r_state   <= ST_SEND;
                        r_gap_cnt <= {GAP_W{1'b0}};
                    end else begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= r_gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    r_state   <= ST_SEND;
                    r_gap_cnt <= {GAP_W{1'b0}};
                end
            endcase
        end
    end

endmodule
